// File: rtl/mips_defs.sv
// Shared MIPS pipeline constants: fetch window, reset/exception vectors,
// exception codes and the canonical nop encoding.
package mips_defs;

  localparam logic [31:0] PC_RESET  = 32'h0000_3000;
  localparam logic [31:0] EXC_ENTRY = 32'h0000_4180;
  localparam logic [31:0] IM_LO     = 32'h0000_3000;
  localparam logic [31:0] IM_HI     = 32'h0000_6FFC;

  localparam logic [4:0]  EXC_NONE  = 5'd0;
  localparam logic [4:0]  EXC_ADEL  = 5'd4;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

endpackage

// File: rtl/if_addr_check.sv
// Address legality check and clamp for a word-indexed memory window.
// Illegal addresses (misaligned or outside [IM_LO, IM_HI]) are redirected
// to the base word so the memory is never indexed out of range.
module if_addr_check
  import mips_defs::*;
#(
  parameter logic [31:0] LO = IM_LO,
  parameter logic [31:0] HI = IM_HI
) (
  input  logic [31:0] pc,
  output logic        fetch_ok,
  output logic [12:0] im_addr
);

  // Legality test on the byte address, then pick the real or clamped word index
  always_comb begin
    fetch_ok = (pc[1:0] == 2'b00) && (pc >= LO) && (pc <= HI);
    im_addr  = fetch_ok ? pc[14:2] : LO[14:2];
  end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, picks the next PC from
// exception / stall / redirect / pending-redirect / sequential sources,
// and registers the fetched word into the IF/ID pipeline register.
// A redirect that arrives while stalled is parked and applied on the
// first unstalled edge.
module if_fetch_unit
  import mips_defs::*;
#(
  parameter logic [31:0] PC_RESET_P  = PC_RESET,
  parameter logic [31:0] EXC_ENTRY_P = EXC_ENTRY,
  parameter logic [31:0] IM_LO_P     = IM_LO,
  parameter logic [31:0] IM_HI_P     = IM_HI,
  parameter bit          DELAY_SLOT  = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        exc_req,
  output logic [12:0] im_addr,
  input  logic [31:0] im_data,
  output logic        id_valid,
  output logic [31:0] id_pc,
  output logic [31:0] id_instr,
  output logic [4:0]  id_exc
);

  logic [31:0] pc;
  logic        pend_valid;
  logic [31:0] pend_pc;
  logic        fetch_ok;
  logic        redirecting;

  if_addr_check #(
    .LO (IM_LO_P),
    .HI (IM_HI_P)
  ) u_addr_check (
    .pc       (pc),
    .fetch_ok (fetch_ok),
    .im_addr  (im_addr)
  );

  // A redirect is being applied this edge when unstalled and either source is active
  always_comb begin
    redirecting = redirect_valid || pend_valid;
  end

  // PC sequencing, pending-redirect bookkeeping and IF/ID register load
  always_ff @(posedge clk) begin
    if (reset) begin
      pc         <= PC_RESET_P;
      pend_valid <= 1'b0;
      pend_pc    <= 32'h0;
      id_valid   <= 1'b0;
      id_pc      <= 32'h0;
      id_instr   <= NOP_INSTR;
      id_exc     <= EXC_NONE;
    end else if (exc_req) begin
      pc         <= EXC_ENTRY_P;
      pend_valid <= 1'b0;
      id_valid   <= 1'b0;
      id_pc      <= pc;
      id_instr   <= NOP_INSTR;
      id_exc     <= EXC_NONE;
    end else if (stall) begin
      if (redirect_valid) begin
        pend_valid <= 1'b1;
        pend_pc    <= redirect_pc;
      end
    end else begin
      if (redirect_valid) begin
        pc         <= redirect_pc;
        pend_valid <= 1'b0;
      end else if (pend_valid) begin
        pc         <= pend_pc;
        pend_valid <= 1'b0;
      end else begin
        pc <= pc + 32'd4;
      end

      id_pc <= pc;
      if (!DELAY_SLOT && redirecting) begin
        id_valid <= 1'b0;
        id_instr <= NOP_INSTR;
        id_exc   <= EXC_NONE;
      end else if (fetch_ok) begin
        id_valid <= 1'b1;
        id_instr <= im_data;
        id_exc   <= EXC_NONE;
      end else begin
        id_valid <= 1'b1;
        id_instr <= NOP_INSTR;
        id_exc   <= EXC_ADEL;
      end
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: two instances (delay slot on / off) share the
// same control inputs; a behavioural model predicts PC flow and IF/ID
// contents for both. Directed scenarios first, then random traffic.
module tb_if_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        exc_req;

  logic [12:0] im_addr_a, im_addr_b;
  logic [31:0] im_data_a, im_data_b;
  logic        id_valid_a, id_valid_b;
  logic [31:0] id_pc_a, id_pc_b;
  logic [31:0] id_instr_a, id_instr_b;
  logic [4:0]  id_exc_a, id_exc_b;

  logic [31:0] imem [0:8191];

  int checks = 0;
  int passed = 0;

  // model state: shared PC flow, per-instance IF/ID (0 = delay slot, 1 = flush)
  logic [31:0] m_pc;
  logic        m_pend_v;
  logic [31:0] m_pend_pc;
  logic        m_valid [0:1];
  logic [31:0] m_idpc  [0:1];
  logic [31:0] m_instr [0:1];
  logic [4:0]  m_exc   [0:1];

  always #5 clk = ~clk;

  assign im_data_a = imem[im_addr_a];
  assign im_data_b = imem[im_addr_b];

  if_fetch_unit #(.DELAY_SLOT(1'b1)) dut (
    .clk            (clk),
    .reset          (reset),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .exc_req        (exc_req),
    .im_addr        (im_addr_a),
    .im_data        (im_data_a),
    .id_valid       (id_valid_a),
    .id_pc          (id_pc_a),
    .id_instr       (id_instr_a),
    .id_exc         (id_exc_a)
  );

  if_fetch_unit #(.DELAY_SLOT(1'b0)) dut_flush (
    .clk            (clk),
    .reset          (reset),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .exc_req        (exc_req),
    .im_addr        (im_addr_b),
    .im_data        (im_data_b),
    .id_valid       (id_valid_b),
    .id_pc          (id_pc_b),
    .id_instr       (id_instr_b),
    .id_exc         (id_exc_b)
  );

  function automatic bit legal(input logic [31:0] a);
    return (a % 4 == 0) && (a >= 32'h3000) && (a <= 32'h6FFC);
  endfunction

  function automatic logic [31:0] word_index(input logic [31:0] a);
    return legal(a) ? ((a / 4) % 8192) : 32'h0C00;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      $display("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
      $error("[TB] check %s", tag);
    end
  endtask

  task automatic check_output();
    chk("im_addr_ds",   {19'h0, im_addr_a},  word_index(m_pc));
    chk("id_valid_ds",  {31'h0, id_valid_a}, {31'h0, m_valid[0]});
    chk("id_pc_ds",     id_pc_a,             m_idpc[0]);
    chk("id_instr_ds",  id_instr_a,          m_instr[0]);
    chk("id_exc_ds",    {27'h0, id_exc_a},   {27'h0, m_exc[0]});
    chk("im_addr_fl",   {19'h0, im_addr_b},  word_index(m_pc));
    chk("id_valid_fl",  {31'h0, id_valid_b}, {31'h0, m_valid[1]});
    chk("id_pc_fl",     id_pc_b,             m_idpc[1]);
    chk("id_instr_fl",  id_instr_b,          m_instr[1]);
    chk("id_exc_fl",    {27'h0, id_exc_b},   {27'h0, m_exc[1]});
  endtask

  // drive one cycle of inputs, advance the model, clock, then compare
  task automatic apply_stimulus(input logic rst, input logic st, input logic rv,
                                input logic [31:0] rpc, input logic ex);
    logic [31:0] fetched_pc;
    logic [31:0] target;
    bit          jumping;
    reset = rst; stall = st; redirect_valid = rv; redirect_pc = rpc; exc_req = ex;
    fetched_pc = m_pc;
    if (rst) begin
      m_pc = 32'h3000; m_pend_v = 1'b0; m_pend_pc = 32'h0;
      for (int k = 0; k < 2; k++) begin
        m_valid[k] = 1'b0; m_idpc[k] = 32'h0; m_instr[k] = 32'h0; m_exc[k] = 5'd0;
      end
    end else if (ex) begin
      m_pc = 32'h4180; m_pend_v = 1'b0;
      for (int k = 0; k < 2; k++) begin
        m_valid[k] = 1'b0; m_idpc[k] = fetched_pc; m_instr[k] = 32'h0; m_exc[k] = 5'd0;
      end
    end else if (st) begin
      if (rv) begin
        m_pend_v = 1'b1; m_pend_pc = rpc;
      end
    end else begin
      jumping = rv || m_pend_v;
      target  = rv ? rpc : (m_pend_v ? m_pend_pc : fetched_pc + 32'd4);
      m_pc = target; m_pend_v = 1'b0;
      for (int k = 0; k < 2; k++) begin
        m_idpc[k] = fetched_pc;
        if (k == 1 && jumping) begin
          m_valid[k] = 1'b0; m_instr[k] = 32'h0; m_exc[k] = 5'd0;
        end else if (legal(fetched_pc)) begin
          m_valid[k] = 1'b1; m_instr[k] = imem[word_index(fetched_pc)]; m_exc[k] = 5'd0;
        end else begin
          m_valid[k] = 1'b1; m_instr[k] = 32'h0; m_exc[k] = 5'd4;
        end
      end
    end
    @(posedge clk);
    #1;
    check_output();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) apply_stimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
  endtask

  initial begin
    logic [31:0] rpc;
    for (int i = 0; i < 8192; i++) imem[i] = $urandom;
    imem[13'h0C00] = 32'h2401_0001;
    imem[13'h0C01] = 32'h2402_0002;
    imem[13'h0C02] = 32'h2403_0003;
    reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0; exc_req = 1'b0;
    m_pc = 32'h0; m_pend_v = 1'b0; m_pend_pc = 32'h0;

    // reset held two cycles, then free-run from 0x3000
    apply_stimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    apply_stimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    idle(2);

    // stall three cycles at 0x3008, then resume at 0x300C
    for (int i = 0; i < 3; i++) apply_stimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    idle(2);

    // redirect parked under stall, applied on first unstalled edge
    apply_stimulus(1'b0, 1'b1, 1'b1, 32'h3100, 1'b0);
    apply_stimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    idle(2);

    // plain redirect: the flush instance bubbles IF/ID
    apply_stimulus(1'b0, 1'b0, 1'b1, 32'h3200, 1'b0);
    idle(1);

    // exception beats stall and redirect, pending target discarded
    apply_stimulus(1'b0, 1'b1, 1'b1, 32'h3300, 1'b1);
    idle(2);

    // misaligned and out-of-window fetches raise AdEL without halting
    apply_stimulus(1'b0, 1'b0, 1'b1, 32'h3002, 1'b0);
    idle(2);
    apply_stimulus(1'b0, 1'b0, 1'b1, 32'h7000, 1'b0);
    idle(2);
    apply_stimulus(1'b0, 1'b0, 1'b1, 32'h6FFC, 1'b0);
    idle(2);

    // reset while stalled with a pending redirect
    apply_stimulus(1'b0, 1'b1, 1'b1, 32'h3400, 1'b0);
    apply_stimulus(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
    idle(2);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 3))
        0:       rpc = $urandom;
        1:       rpc = 32'h6FF0 + 4 * $urandom_range(0, 7);
        default: rpc = 32'h3000 + 4 * $urandom_range(0, 4095);
      endcase
      apply_stimulus($urandom_range(0, 99) < 2,
                     $urandom_range(0, 99) < 25,
                     $urandom_range(0, 99) < 20,
                     rpc,
                     $urandom_range(0, 99) < 4);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
